// File: rtl/ritc_vcdl_phase_scan.sv
// VCDL phase-scan calibration sequencer: fires VCDL pulses, samples the feedback
// bit and steps the MMCM phase shift to locate the first rising VCDL edge.
module ritc_vcdl_phase_scan #(
    parameter int STEP_BITS  = 8,
    parameter int NPULSE     = 16,
    parameter int SETTLE     = 32,
    parameter int PS_TIMEOUT = 255
) (
    input  logic                        user_clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic                        abort_i,
    input  logic [STEP_BITS-1:0]        nsteps_i,
    input  logic                        vcdl_ps_q_i,
    output logic                        vcdl_pulse_o,
    output logic                        ps_en_o,
    output logic                        ps_incdec_o,
    input  logic                        ps_done_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        edge_found_o,
    output logic [STEP_BITS-1:0]        edge_step_o,
    output logic                        timeout_o,
    output logic [$clog2(NPULSE):0]     hits_o
);

    localparam int HB = $clog2(NPULSE) + 1;
    localparam int SB = $clog2(SETTLE);
    localparam int WB = $clog2(PS_TIMEOUT + 1);

    localparam logic [HB-1:0] NPULSE_C    = HB'(NPULSE);
    localparam logic [HB-1:0] HALF_C      = HB'(NPULSE / 2);
    localparam logic [SB-1:0] SETTLE_LAST = SB'(SETTLE - 2);
    localparam logic [WB-1:0] WAIT_LAST   = WB'(PS_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PULSE   = 3'd1,
        S_SETTLE  = 3'd2,
        S_SAMPLE  = 3'd3,
        S_EVAL    = 3'd4,
        S_PS_REQ  = 3'd5,
        S_PS_WAIT = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    state_t               state_q;
    logic [1:0]           sync_q;
    logic [STEP_BITS-1:0] step_q;
    logic [HB-1:0]        hits_q;
    logic [HB-1:0]        pcount_q;
    logic [SB-1:0]        scnt_q;
    logic [WB-1:0]        wcnt_q;
    logic                 prev_high_q;
    logic                 vcdl_pulse_q;
    logic                 ps_en_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 edge_found_q;
    logic [STEP_BITS-1:0] edge_step_q;
    logic                 timeout_q;
    logic [HB-1:0]        hits_out_q;

    logic [STEP_BITS-1:0] last_step_d;
    logic [HB-1:0]        hits_d;
    logic [HB-1:0]        pcount_d;
    logic                 high_d;

    // Step bound, saturating hit count and the majority decision for this step
    always_comb begin
        last_step_d = (nsteps_i == {STEP_BITS{1'b0}}) ? {STEP_BITS{1'b0}}
                                                      : nsteps_i - STEP_BITS'(1);
        hits_d      = (sync_q[1] && (hits_q != NPULSE_C)) ? hits_q + HB'(1) : hits_q;
        pcount_d    = pcount_q + HB'(1);
        high_d      = (hits_q >= HALF_C);
    end

    // Two-stage synchronizer for the feedback bit sampled on clk_ps
    always_ff @(posedge user_clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], vcdl_ps_q_i};
        end
    end

    // Scan sequencer with registered strobes and results
    always_ff @(posedge user_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            step_q       <= {STEP_BITS{1'b0}};
            hits_q       <= {HB{1'b0}};
            pcount_q     <= {HB{1'b0}};
            scnt_q       <= {SB{1'b0}};
            wcnt_q       <= {WB{1'b0}};
            prev_high_q  <= 1'b0;
            vcdl_pulse_q <= 1'b0;
            ps_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            edge_found_q <= 1'b0;
            edge_step_q  <= {STEP_BITS{1'b0}};
            timeout_q    <= 1'b0;
            hits_out_q   <= {HB{1'b0}};
        end else begin
            vcdl_pulse_q <= 1'b0;
            ps_en_q      <= 1'b0;
            done_q       <= 1'b0;
            if (abort_i && (state_q != S_IDLE)) begin
                // Abort leaves the block quiescent with every output cleared
                state_q      <= S_IDLE;
                busy_q       <= 1'b0;
                edge_found_q <= 1'b0;
                edge_step_q  <= {STEP_BITS{1'b0}};
                timeout_q    <= 1'b0;
                hits_out_q   <= {HB{1'b0}};
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_i) begin
                            step_q       <= {STEP_BITS{1'b0}};
                            hits_q       <= {HB{1'b0}};
                            pcount_q     <= {HB{1'b0}};
                            prev_high_q  <= 1'b0;
                            edge_found_q <= 1'b0;
                            edge_step_q  <= {STEP_BITS{1'b0}};
                            timeout_q    <= 1'b0;
                            busy_q       <= 1'b1;
                            vcdl_pulse_q <= 1'b1;
                            state_q      <= S_PULSE;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                    S_PULSE: begin
                        scnt_q  <= {SB{1'b0}};
                        state_q <= S_SETTLE;
                    end
                    S_SETTLE: begin
                        if (scnt_q == SETTLE_LAST) begin
                            state_q <= S_SAMPLE;
                        end else begin
                            scnt_q <= scnt_q + SB'(1);
                        end
                    end
                    S_SAMPLE: begin
                        hits_q   <= hits_d;
                        pcount_q <= pcount_d;
                        if (pcount_d == NPULSE_C) begin
                            state_q <= S_EVAL;
                        end else begin
                            vcdl_pulse_q <= 1'b1;
                            state_q      <= S_PULSE;
                        end
                    end
                    S_EVAL: begin
                        // Only the first low-to-high transition after step 0 is an edge
                        if (high_d && !prev_high_q && !edge_found_q &&
                            (step_q != {STEP_BITS{1'b0}})) begin
                            edge_found_q <= 1'b1;
                            edge_step_q  <= step_q;
                        end
                        hits_out_q  <= hits_q;
                        prev_high_q <= high_d;
                        if (step_q == last_step_d) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            ps_en_q <= 1'b1;
                            state_q <= S_PS_REQ;
                        end
                    end
                    S_PS_REQ: begin
                        wcnt_q  <= {WB{1'b0}};
                        state_q <= S_PS_WAIT;
                    end
                    S_PS_WAIT: begin
                        if (ps_done_i) begin
                            step_q       <= step_q + STEP_BITS'(1);
                            hits_q       <= {HB{1'b0}};
                            pcount_q     <= {HB{1'b0}};
                            vcdl_pulse_q <= 1'b1;
                            state_q      <= S_PULSE;
                        end else if (wcnt_q == WAIT_LAST) begin
                            timeout_q <= 1'b1;
                            done_q    <= 1'b1;
                            state_q   <= S_DONE;
                        end else begin
                            wcnt_q <= wcnt_q + WB'(1);
                        end
                    end
                    S_DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign vcdl_pulse_o = vcdl_pulse_q;
    assign ps_en_o      = ps_en_q;
    assign ps_incdec_o  = 1'b1;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign edge_found_o = edge_found_q;
    assign edge_step_o  = edge_step_q;
    assign timeout_o    = timeout_q;
    assign hits_o       = hits_out_q;

endmodule

// File: tb/tb_ritc_vcdl_phase_scan.sv
// Randomized bench for ritc_vcdl_phase_scan: a per-step hit pattern drives the
// feedback bit and expected results are derived from the scan rules.
module tb_ritc_vcdl_phase_scan;

    localparam int NPULSE     = 16;
    localparam int SETTLE     = 32;
    localparam int PS_TIMEOUT = 255;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic       abort_i;
    logic [7:0] nsteps_i;
    logic       vcdl_ps_q_i;
    logic       vcdl_pulse_o;
    logic       ps_en_o;
    logic       ps_incdec_o;
    logic       ps_done_i;
    logic       busy_o;
    logic       done_o;
    logic       edge_found_o;
    logic [7:0] edge_step_o;
    logic       timeout_o;
    logic [4:0] hits_o;

    int n_vec = 0;
    int n_err = 0;
    int hits_pat [0:255];

    ritc_vcdl_phase_scan #(
        .STEP_BITS(8), .NPULSE(NPULSE), .SETTLE(SETTLE), .PS_TIMEOUT(PS_TIMEOUT)
    ) dut (
        .user_clk_i   (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .nsteps_i     (nsteps_i),
        .vcdl_ps_q_i  (vcdl_ps_q_i),
        .vcdl_pulse_o (vcdl_pulse_o),
        .ps_en_o      (ps_en_o),
        .ps_incdec_o  (ps_incdec_o),
        .ps_done_i    (ps_done_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .edge_found_o (edge_found_o),
        .edge_step_o  (edge_step_o),
        .timeout_o    (timeout_o),
        .hits_o       (hits_o)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        n_vec++;
        if ({vcdl_pulse_o, ps_en_o, busy_o, done_o, edge_found_o, timeout_o} !== 6'b0 ||
            edge_step_o !== 8'd0 || hits_o !== 5'd0 || ps_incdec_o !== 1'b1) begin
            n_err++;
            $display("FAIL reset_state: pulse=%b en=%b busy=%b done=%b ef=%b to=%b es=%0d hits=%0d incdec=%b, required all 0 and incdec=1",
                     vcdl_pulse_o, ps_en_o, busy_o, done_o, edge_found_o, timeout_o,
                     edge_step_o, hits_o, ps_incdec_o);
        end
    endtask

    // Drives one complete scan; lat<=0 means ps_done_i never arrives
    task automatic run_scan(input string name, input int nsteps, input int lat, input int restart_at);
        int  cyc, pulses, ens, dones, tstep, k, cd, first_en, done_cyc, last, estep, hits_exp, i;
        bit  got, to_exp, found;
        cyc = 0; pulses = 0; ens = 0; dones = 0; tstep = 0; k = 0; cd = 0;
        first_en = -1; done_cyc = -1; got = 1'b0;
        @(negedge clk);
        nsteps_i = nsteps[7:0]; start_i = 1'b1; vcdl_ps_q_i = 1'b0; ps_done_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        n_vec++;
        if (busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL %s busy_after_start: got %b, required 1", name, busy_o);
        end
        while (!got && cyc < 20000) begin
            start_i   = (cyc == restart_at) ? 1'b1 : 1'b0;
            ps_done_i = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) ps_done_i = 1'b1;
            end
            if (vcdl_pulse_o) begin
                vcdl_ps_q_i = (k < hits_pat[tstep]);
                k++;
                pulses++;
            end
            if (ps_en_o) begin
                ens++;
                tstep++;
                k = 0;
                if (first_en < 0) first_en = cyc;
                cd = (lat > 0) ? lat : 0;
            end
            if (done_o) begin
                dones++;
                done_cyc = cyc;
                got = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        start_i = 1'b0; ps_done_i = 1'b0;

        last   = (nsteps == 0) ? 0 : nsteps - 1;
        to_exp = (lat <= 0) && (last > 0);
        if (to_exp) last = 0;
        found = 1'b0; estep = 0;
        for (i = 1; i <= last; i++) begin
            if (!found && hits_pat[i] >= NPULSE / 2 && hits_pat[i-1] < NPULSE / 2) begin
                found = 1'b1;
                estep = i;
            end
        end
        hits_exp = hits_pat[last];

        n_vec++;
        if (dones !== 1) begin
            n_err++;
            $display("FAIL %s done_seen: got %0d done pulses, required 1", name, dones);
        end
        n_vec++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL %s after_done: done=%b busy=%b, required 0 0", name, done_o, busy_o);
        end
        n_vec++;
        if (pulses !== NPULSE * (last + 1)) begin
            n_err++;
            $display("FAIL %s pulse_count: got %0d, required %0d", name, pulses, NPULSE * (last + 1));
        end
        n_vec++;
        if (ens !== (to_exp ? 1 : last)) begin
            n_err++;
            $display("FAIL %s ps_en_count: got %0d, required %0d", name, ens, to_exp ? 1 : last);
        end
        n_vec++;
        if (edge_found_o !== found || edge_step_o !== estep[7:0]) begin
            n_err++;
            $display("FAIL %s edge: got found=%b step=%0d, required found=%b step=%0d",
                     name, edge_found_o, edge_step_o, found, estep);
        end
        n_vec++;
        if (hits_o !== hits_exp[4:0]) begin
            n_err++;
            $display("FAIL %s hits: got %0d, required %0d", name, hits_o, hits_exp);
        end
        n_vec++;
        if (timeout_o !== to_exp) begin
            n_err++;
            $display("FAIL %s timeout_flag: got %b, required %b", name, timeout_o, to_exp);
        end
        if (to_exp) begin
            n_vec++;
            if (done_cyc - first_en !== PS_TIMEOUT + 1) begin
                n_err++;
                $display("FAIL %s timeout_latency: got %0d, required %0d",
                         name, done_cyc - first_en, PS_TIMEOUT + 1);
            end
        end
    endtask

    task automatic test_no_feedback();
        for (int i = 0; i < 256; i++) hits_pat[i] = 0;
        run_scan("no_feedback", 4, 3, -1);
    endtask

    task automatic test_edge_at_6();
        for (int i = 0; i < 256; i++) hits_pat[i] = (i >= 6) ? NPULSE : 0;
        run_scan("edge_at_6", 10, 1, -1);
    endtask

    task automatic test_all_high();
        for (int i = 0; i < 256; i++) hits_pat[i] = NPULSE;
        run_scan("all_high", 6, 2, -1);
    endtask

    task automatic test_first_edge_only();
        for (int i = 0; i < 256; i++)
            hits_pat[i] = (i == 3 || i == 4) ? NPULSE / 2 : ((i >= 7) ? NPULSE : 0);
        run_scan("first_edge_only", 9, 2, -1);
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 256; i++) hits_pat[i] = 5;
        run_scan("timeout", 5, 0, -1);
    endtask

    task automatic test_nsteps_zero();
        for (int i = 0; i < 256; i++) hits_pat[i] = 11;
        run_scan("nsteps_zero", 0, 1, -1);
    endtask

    task automatic test_random();
        int choices [0:5];
        choices[0] = 0; choices[1] = 7; choices[2] = 8;
        choices[3] = 9; choices[4] = 16; choices[5] = 3;
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 256; i++) hits_pat[i] = choices[$urandom_range(5, 0)];
            run_scan("random", $urandom_range(12, 1), $urandom_range(6, 1),
                     (r == 2) ? 200 : -1);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        for (int i = 0; i < 256; i++) hits_pat[i] = NPULSE;
        @(negedge clk);
        nsteps_i = 8'd4; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (10) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        n_vec++;
        if ({vcdl_pulse_o, ps_en_o, busy_o, done_o, edge_found_o, timeout_o} !== 6'b0 ||
            edge_step_o !== 8'd0 || hits_o !== 5'd0) begin
            n_err++;
            $display("FAIL reset_mid: pulse=%b en=%b busy=%b done=%b ef=%b to=%b es=%0d hits=%0d, required all 0",
                     vcdl_pulse_o, ps_en_o, busy_o, done_o, edge_found_o, timeout_o, edge_step_o, hits_o);
        end
        bad = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (vcdl_pulse_o || ps_en_o || done_o || busy_o) bad++;
        end
        n_vec++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL reset_mid_quiet: got %0d active cycles, required 0", bad);
        end
    endtask

    task automatic test_abort();
        int bad, c;
        for (int i = 0; i < 256; i++) hits_pat[i] = NPULSE;
        @(negedge clk);
        nsteps_i = 8'd3; start_i = 1'b1; vcdl_ps_q_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        c = 0;
        while (!ps_en_o && c < 2000) begin
            @(negedge clk);
            c++;
        end
        n_vec++;
        if (!ps_en_o) begin
            n_err++;
            $display("FAIL abort_reach_ps: got no ps_en within %0d cycles, required one", c);
        end
        repeat (6) @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        n_vec++;
        if ({vcdl_pulse_o, ps_en_o, busy_o, done_o, edge_found_o, timeout_o} !== 6'b0 ||
            edge_step_o !== 8'd0 || hits_o !== 5'd0) begin
            n_err++;
            $display("FAIL abort_state: pulse=%b en=%b busy=%b done=%b ef=%b to=%b es=%0d hits=%0d, required all 0",
                     vcdl_pulse_o, ps_en_o, busy_o, done_o, edge_found_o, timeout_o, edge_step_o, hits_o);
        end
        bad = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (vcdl_pulse_o || ps_en_o || done_o || busy_o || timeout_o) bad++;
        end
        n_vec++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL abort_quiet: got %0d active cycles, required 0", bad);
        end
        vcdl_ps_q_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; nsteps_i = 8'd0;
        vcdl_ps_q_i = 1'b0; ps_done_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        test_reset();
        test_no_feedback();
        test_edge_at_6();
        test_all_high();
        test_first_edge_only();
        test_timeout();
        test_nsteps_zero();
        test_random();
        test_reset_mid();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ritc_vcdl_phase_scan.md
Name: ritc_vcdl_phase_scan

Overview:
- Calibration sequencer in the user_clk domain, directly upstream of the RITC VCDL generator.
- Fires single VCDL pulse requests into the generator's vcdl_pulse input and samples the returned feedback bit (vcdl_ps_q) on the phase-shifted clock.
- Steps the MMCM dynamic phase shift that produces clk_ps across a programmed range to locate the VCDL output edge.
- Reports the edge step and a completion flag to the register block.

Parameters:
- STEP_BITS, 8, width of the step counter, edge result and step-count input.
- NPULSE, 16, VCDL pulses per phase step; power of two, minimum 2.
- SETTLE, 32, cycles from a pulse request to its feedback sample; minimum 4.
- PS_TIMEOUT, 255, maximum cycles to wait for ps_done_i.

Ports:
- user_clk_i, input, 1, block clock.
- rst_i, input, 1, asynchronous active-high reset.
- start_i, input, 1, single-cycle scan request; honoured only in IDLE.
- abort_i, input, 1, synchronous abort; returns the block to IDLE.
- nsteps_i, input, STEP_BITS, number of phase steps to scan (0 means 1).
- vcdl_ps_q_i, input, 1, VCDL feedback bit from the VCDL generator.
- vcdl_pulse_o, output, 1, single-cycle pulse request to the VCDL generator.
- ps_en_o, output, 1, single-cycle MMCM phase-shift enable.
- ps_incdec_o, output, 1, phase-shift direction; always 1 (increment).
- ps_done_i, input, 1, MMCM phase-shift done.
- busy_o, output, 1, scan in progress.
- done_o, output, 1, single-cycle pulse at scan end.
- edge_found_o, output, 1, sticky result flag valid after done_o.
- edge_step_o, output, STEP_BITS, step at which the edge was found.
- timeout_o, output, 1, sticky; set when ps_done_i did not arrive within PS_TIMEOUT cycles.
- hits_o, output, log2(NPULSE)+1, hit count of the last completed step (debug).

Behaviour:
- Reset: all outputs 0 and FSM in IDLE. Reset asserted mid-scan discards all state with no trailing ps_en_o or vcdl_pulse_o.
- vcdl_ps_q_i passes through a 2-FF synchronizer; sampling uses the synchronized value.
- IDLE -> PULSE on start_i. In the same transition: step=0, hits=0, pcount=0, prev_high=0; clear edge_found_o, edge_step_o and timeout_o.
- busy_o is high in every state except IDLE; it goes high the cycle after start_i.
- PULSE: vcdl_pulse_o=1 for exactly one cycle, then SETTLE.
- SETTLE: wait SETTLE-1 cycles, then SAMPLE.
- SAMPLE (1 cycle): if the synchronized bit is 1, hits+=1; pcount+=1. If pcount reaches NPULSE, go to EVAL; otherwise go to PULSE.
- EVAL (1 cycle):
  - high = (hits >= NPULSE/2).
  - If high, prev_high=0 and edge_found_o=0, then set edge_found_o=1 and edge_step_o=step. Only the first rising transition is recorded.
  - A step-0 high is not an edge.
  - hits_o is loaded with hits; then prev_high=high.
  - If step == max(nsteps_i,1)-1, go to DONE; otherwise go to PS_REQ.
- PS_REQ: ps_en_o=1 for one cycle, then PS_WAIT.
- PS_WAIT:
  - On ps_done_i: step+=1, hits=0, pcount=0, then PULSE.
  - After PS_TIMEOUT cycles without ps_done_i: set timeout_o and go to DONE.
  - ps_done_i outside PS_WAIT is ignored.
- DONE: done_o=1 for one cycle, then IDLE. Results hold until the next start_i.
- abort_i in any non-IDLE state: go to IDLE next cycle; done_o is not asserted. abort_i takes priority over any event in the same cycle.
- start_i while busy is ignored.
- Arithmetic:
  - hits saturates at NPULSE; it cannot exceed NPULSE by construction.
  - The step counter cannot wrap because nsteps_i bounds it.
  - The MMCM phase is not restored; software resets the MMCM or rescans.
- Latency per step: NPULSE*(SETTLE+1)+1 cycles, plus ps_done latency plus 1.

Test Plan:
1. nsteps_i=4, feedback tied 0, ps_done_i 3 cycles after ps_en_o:
   - Expect 64 vcdl_pulse_o pulses and 3 ps_en_o pulses.
   - Expect done_o with edge_found_o=0 and hits_o=0.
2. nsteps_i=10, feedback=1 only when step>=6, ps_done_i prompt:
   - Expect edge_found_o=1, edge_step_o=6, hits_o=16.
3. Feedback high at all steps:
   - Expect edge_found_o=0 (step-0 high is not an edge).
4. Feedback at 50% duty (8 of 16 hits) from step 3, then back to 0 at step 5, then high again at step 7:
   - Expect edge_step_o=3 (first rising transition only).
5. ps_done_i never asserted:
   - Expect timeout_o=1 and done_o exactly PS_TIMEOUT+1 cycles after the first ps_en_o.
   - Expect no further vcdl_pulse_o.
6. rst_i asserted mid-SETTLE, and separately abort_i mid-PS_WAIT:
   - Expect all outputs 0 and IDLE on the next cycle, with no done_o.
   - start_i issued while busy has no effect.
